// File: rtl/seq_adder128_pkg.sv
// Shared constants and encodings for the seq_adder128 execution stage.
package alu_pkg;

  localparam int unsigned DATA_W = 128;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Arithmetic-mode operand-B selection; codes 1xx fall back to Bop = 0.
  typedef enum logic [2:0] {
    OP_PASS = 3'b000,
    OP_ADD  = 3'b001,
    OP_SUB  = 3'b010,
    OP_DEC  = 3'b011
  } opsel_t;

  // Logic-mode codes share the same Opsel field.
  localparam logic [2:0] LG_AND = 3'b000;
  localparam logic [2:0] LG_OR  = 3'b001;
  localparam logic [2:0] LG_XOR = 3'b010;
  localparam logic [2:0] LG_NOT = 3'b011;

endpackage

// File: rtl/seq_adder128_if.sv
// Request/response bundle for seq_adder128; Zero exists only with SEQADD_ZERO_FLAG_EN.
interface seq_adder128_if #(
  parameter int unsigned DATA_W = alu_pkg::DATA_W
);
  logic              Start;
  logic [DATA_W-1:0] A;
  logic [DATA_W-1:0] B;
  logic [2:0]        Opsel;
  logic              Mode;
  logic              Cin;
  logic              Busy;
  logic              Done;
  logic [DATA_W-1:0] Result;
  logic              Cout;
  logic              Overflow;
`ifdef SEQADD_ZERO_FLAG_EN
  logic              Zero;
`endif

  modport master (
    output Start, A, B, Opsel, Mode, Cin,
`ifdef SEQADD_ZERO_FLAG_EN
    input  Zero,
`endif
    input  Busy, Done, Result, Cout, Overflow
  );

  modport slave (
    input  Start, A, B, Opsel, Mode, Cin,
`ifdef SEQADD_ZERO_FLAG_EN
    output Zero,
`endif
    output Busy, Done, Result, Cout, Overflow
  );

endinterface

// File: rtl/seq_adder128_slice_alu.sv
// Combinational one-slice ALU: arithmetic add with selectable B operand, or bitwise logic.
module slice_alu #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   opsel,
  input  logic         mode,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         cout,
  output logic         c_msb
);
  import alu_pkg::*;

  logic [W-1:0] bop;
  logic [W-1:0] lo;
  logic [1:0]   hi;
  logic [W-1:0] lg;

  always_comb begin
    bop = '0;
    case (opsel)
      OP_PASS: bop = '0;
      OP_ADD:  bop = b;
      OP_SUB:  bop = ~b;
      OP_DEC:  bop = '1;
      default: bop = '0;
    endcase
  end

  // Split the add at the MSB so the carry into it is visible for overflow.
  always_comb begin
    lo = {1'b0, a[W-2:0]} + {1'b0, bop[W-2:0]} + {{(W-1){1'b0}}, cin};
    hi = {1'b0, a[W-1]} + {1'b0, bop[W-1]} + {1'b0, lo[W-1]};
  end

  always_comb begin
    lg = a;
    case (opsel)
      LG_AND:  lg = a & b;
      LG_OR:   lg = a | b;
      LG_XOR:  lg = a ^ b;
      LG_NOT:  lg = ~a;
      default: lg = a;
    endcase
  end

  always_comb begin
    if (mode) begin
      y     = {hi[0], lo[W-2:0]};
      cout  = hi[1];
      c_msb = lo[W-1];
    end else begin
      y     = lg;
      cout  = 1'b0;
      c_msb = 1'b0;
    end
  end

endmodule

// File: rtl/seq_adder128.sv
// Multi-cycle ALU stage: one SLICE_W slice per cycle, carry rippled through a register.
// Optional Zero flag output enabled by defining SEQADD_ZERO_FLAG_EN.
module seq_adder128 #(
  parameter int unsigned DATA_W  = alu_pkg::DATA_W,
  parameter int unsigned SLICE_W = 32
) (
  input  logic          Clk,
  input  logic          Reset,
  seq_adder128_if.slave bus
);
  import alu_pkg::*;

  localparam int unsigned NUM_SLICES = DATA_W / SLICE_W;
  localparam int unsigned IDX_W      = (NUM_SLICES > 1) ? $clog2(NUM_SLICES) : 1;

  if ((DATA_W % SLICE_W) != 0 || SLICE_W < 2) begin : g_bad_width
    $error("seq_adder128: DATA_W must be a multiple of SLICE_W (SLICE_W >= 2)");
  end

  state_t              state;
  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   a_q;
  logic [DATA_W-1:0]   b_q;
  logic [2:0]          opsel_q;
  logic                mode_q;
  logic                carry_q;
  logic [DATA_W-1:0]   acc;
  logic [DATA_W-1:0]   acc_next;
  logic [DATA_W-1:0]   result_q;
  logic                cout_q;
  logic                ovf_q;
  logic [SLICE_W-1:0]  s_a;
  logic [SLICE_W-1:0]  s_b;
  logic [SLICE_W-1:0]  s_y;
  logic                s_cout;
  logic                s_cmsb;
  logic                last;

  always_comb begin
    s_a  = a_q[idx*SLICE_W +: SLICE_W];
    s_b  = b_q[idx*SLICE_W +: SLICE_W];
    last = (idx == IDX_W'(NUM_SLICES - 1));
  end

  slice_alu #(.W(SLICE_W)) u_slice (
    .a     (s_a),
    .b     (s_b),
    .opsel (opsel_q),
    .mode  (mode_q),
    .cin   (carry_q),
    .y     (s_y),
    .cout  (s_cout),
    .c_msb (s_cmsb)
  );

  // Output registers load from the merged accumulator on the final slice, so
  // Result is already valid in the DONE cycle.
  always_comb begin
    acc_next = acc;
    acc_next[idx*SLICE_W +: SLICE_W] = s_y;
  end

`ifdef SEQADD_ZERO_FLAG_EN
  logic zero_q;
  always_ff @(posedge Clk) begin
    if (Reset)
      zero_q <= 1'b0;
    else if (state == RUN && last)
      zero_q <= (acc_next == '0);
  end
  assign bus.Zero = zero_q;
`endif

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state    <= IDLE;
      idx      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      opsel_q  <= '0;
      mode_q   <= 1'b0;
      carry_q  <= 1'b0;
      acc      <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (bus.Start) begin
            a_q     <= bus.A;
            b_q     <= bus.B;
            opsel_q <= bus.Opsel;
            mode_q  <= bus.Mode;
            carry_q <= bus.Cin;
            idx     <= '0;
            state   <= RUN;
          end else begin
            state   <= IDLE;
          end
        end
        RUN: begin
          acc     <= acc_next;
          carry_q <= s_cout;
          if (last) begin
            result_q <= acc_next;
            cout_q   <= s_cout;
            ovf_q    <= s_cout ^ s_cmsb;
            state    <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Busy     = (state == RUN);
  assign bus.Done     = (state == DONE);
  assign bus.Result   = result_q;
  assign bus.Cout     = cout_q;
  assign bus.Overflow = ovf_q;

endmodule
